// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C slave receive path
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BITS,
        WAIT_ACK,
        ACK,
        ACK_HOLD
    } rx_timer_state_t;

    localparam int I2C_DATA_BITS = 8;

    // Bus-idle level of the receive shift register; sliced down to DATA_BITS by users
    localparam logic [15:0] RX_IDLE_DATA = '1;

endpackage

// File: rtl/i2c_bit_counter.sv
// rtl/i2c_bit_counter.sv - 4-bit data-bit counter with clear, enable and rollover flag
module i2c_bit_counter
    import i2c_pkg::*;
#(
    parameter int TERM = I2C_DATA_BITS
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       rollover
);

    localparam logic [3:0] TERM_M1 = 4'(TERM - 1);

    // Count enabled bits; wrap to zero and flag the rollover for one cycle at TERM
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt      <= 4'd0;
            rollover <= 1'b0;
        end else begin
            rollover <= 1'b0;
            if (clr) begin
                cnt <= 4'd0;
            end else if (en) begin
                if (cnt == TERM_M1) begin
                    cnt      <= 4'd0;
                    rollover <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_rx_timer.sv
// rtl/i2c_rx_timer.sv - frames received I2C bytes and sequences the ACK slot
module i2c_rx_timer
    import i2c_pkg::*;
#(
    parameter int DATA_BITS = I2C_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rising_edge_found,
    input  logic                 falling_edge_found,
    input  logic                 sda_in,
    input  logic                 start_found,
    input  logic                 stop_found,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 byte_received,
    output logic                 ack_prep,
    output logic                 check_ack,
    output logic                 ack_done,
    output logic                 busy
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    rx_timer_state_t      state;
    rx_timer_state_t      state_next;
    logic [3:0]           bit_cnt;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 shift_en;
    logic                 ack_prep_next;
    logic                 check_ack_next;
    logic                 ack_done_next;
    logic                 fall_only;
    logic [DATA_BITS-1:0] rx_shifted;

    // A falling strobe coincident with a rising one is dropped
    assign fall_only = falling_edge_found && !rising_edge_found;

    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign rx_shifted = sda_in;
        end else begin : g_shift_many
            assign rx_shifted = {rx_data[DATA_BITS-2:0], sda_in};
        end
    endgenerate

    // byte_received is the counter's registered rollover pulse
    i2c_bit_counter #(
        .TERM (DATA_BITS)
    ) u_bit_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .cnt      (bit_cnt),
        .rollover (byte_received)
    );

    // Next-state and strobe decode; start beats stop beats SCL edges
    always_comb begin
        state_next     = state;
        cnt_clr        = 1'b0;
        cnt_en         = 1'b0;
        shift_en       = 1'b0;
        ack_prep_next  = 1'b0;
        check_ack_next = 1'b0;
        ack_done_next  = 1'b0;
        if (start_found) begin
            state_next = BITS;
            cnt_clr    = 1'b1;
        end else if (stop_found) begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                BITS: begin
                    if (rising_edge_found) begin
                        shift_en = 1'b1;
                        cnt_en   = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_next = WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (fall_only) begin
                        ack_prep_next = 1'b1;
                        state_next    = ACK;
                    end
                end
                ACK: begin
                    if (rising_edge_found) begin
                        check_ack_next = 1'b1;
                        state_next     = ACK_HOLD;
                    end
                end
                ACK_HOLD: begin
                    if (fall_only) begin
                        ack_done_next = 1'b1;
                        state_next    = BITS;
                        cnt_clr       = 1'b1;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // State, strobe and busy registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            ack_prep  <= 1'b0;
            check_ack <= 1'b0;
            ack_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            ack_prep  <= ack_prep_next;
            check_ack <= check_ack_next;
            ack_done  <= ack_done_next;
            busy      <= (state_next != IDLE);
        end
    end

    // MSB-first shift register; held across start/stop so partial bytes stay visible
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data <= RX_IDLE_DATA[DATA_BITS-1:0];
        end else if (shift_en) begin
            rx_data <= rx_shifted;
        end
    end

endmodule

// File: tb/tb_i2c_rx_timer.sv
// tb/tb_i2c_rx_timer.sv - directed self-checking bench for i2c_rx_timer
module tb_i2c_rx_timer;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rising_edge_found;
    logic       falling_edge_found;
    logic       sda_in;
    logic       start_found;
    logic       stop_found;
    logic [7:0] rx_data;
    logic       byte_received;
    logic       ack_prep;
    logic       check_ack;
    logic       ack_done;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int br_total = 0;
    int br_mark;

    i2c_rx_timer #(.DATA_BITS(8)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .rising_edge_found  (rising_edge_found),
        .falling_edge_found (falling_edge_found),
        .sda_in             (sda_in),
        .start_found        (start_found),
        .stop_found         (stop_found),
        .rx_data            (rx_data),
        .byte_received      (byte_received),
        .ack_prep           (ack_prep),
        .check_ack          (check_ack),
        .ack_done           (ack_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_received) br_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic s, input logic st, input logic sp);
        @(negedge clk);
        rising_edge_found  = r;
        falling_edge_found = f;
        sda_in             = s;
        start_found        = st;
        stop_found         = sp;
        @(posedge clk);
        #1;
        rising_edge_found  = 1'b0;
        falling_edge_found = 1'b0;
        start_found        = 1'b0;
        stop_found         = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, b[7-i], 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Seven full bits, then the eighth rise; leaves the DUT in WAIT_ACK
    task automatic send_byte(input string tag, input logic [7:0] b);
        send_bits(b, 7);
        step(1'b1, 1'b0, b[0], 1'b0, 1'b0);
        check({tag, "_byte_received"}, 32'(byte_received), 32'd1);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(b));
    endtask

    task automatic ack_cycle(input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check({tag, "_ack_prep"}, {byte_received, ack_prep, check_ack, ack_done}, 32'b0100);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, "_check_ack"}, {byte_received, ack_prep, check_ack, ack_done}, 32'b0010);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check({tag, "_ack_done"}, {byte_received, ack_prep, check_ack, ack_done}, 32'b0001);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, "_strobes_clear"}, {byte_received, ack_prep, check_ack, ack_done}, 32'b0000);
        check({tag, "_bits_state"}, 32'(dut.state), 32'(BITS));
        check({tag, "_bit_cnt_restart"}, 32'(dut.bit_cnt), 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        rising_edge_found = 1'b0;
        falling_edge_found = 1'b0;
        sda_in = 1'b1;
        start_found = 1'b0;
        stop_found = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(rx_data), 32'hFF);
        check("reset_outputs", {byte_received, ack_prep, check_ack, ack_done, busy}, 32'b00000);
        @(negedge clk);
        n_rst = 1'b1;

        // Edges with no START must be ignored
        send_bits(8'hA5, 8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_no_byte", 32'(br_total), 32'd0);
        check("idle_rx_hold", 32'(rx_data), 32'hFF);

        // Single byte 0xA5 with ACK slot
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("start_busy", 32'(busy), 32'd1);
        send_byte("a5", 8'hA5);
        ack_cycle("a5");

        // Back-to-back bytes with no START between
        send_byte("3c", 8'h3C);
        ack_cycle("3c");
        send_byte("ff", 8'hFF);
        ack_cycle("ff");

        // STOP after five bits discards the partial byte
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_bits(8'b1011_0000, 5);
        br_mark = br_total;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_state", 32'(dut.state), 32'(IDLE));
        check("stop_partial_rx", 32'(rx_data), 32'hF6);
        send_bits(8'h00, 8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stop_no_byte", 32'(br_total), 32'(br_mark));
        check("stop_edges_ignored", 32'(rx_data), 32'hF6);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte("01", 8'h01);
        ack_cycle("01");

        // Repeated START while waiting for the ACK slot
        send_byte("5a", 8'h5A);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("wait_ack_rise_fall", {ack_prep, busy}, 32'b01);
        check("wait_ack_hold_state", 32'(dut.state), 32'(WAIT_ACK));
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rstart_no_ack_prep", {ack_prep, busy}, 32'b01);
        check("rstart_state", 32'(dut.state), 32'(BITS));
        check("rstart_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rstart_fall_ignored", 32'(ack_prep), 32'd0);
        send_byte("80", 8'h80);
        ack_cycle("80");

        // START and STOP together: START wins
        send_bits(8'hE0, 3);
        check("pre_ss_bit_cnt", 32'(dut.bit_cnt), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("start_stop_busy", 32'(busy), 32'd1);
        check("start_stop_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        check("start_stop_state", 32'(dut.state), 32'(BITS));

        // Asynchronous reset cancels a live strobe
        send_bits(8'h55, 7);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_reset_strobe", 32'(byte_received), 32'd1);
        #1;
        n_rst = 1'b0;
        #1;
        check("async_reset_strobe", {byte_received, ack_prep, check_ack, ack_done, busy}, 32'b00000);
        check("async_reset_rx", 32'(rx_data), 32'hFF);
        check("async_reset_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_rx_timer.md
Name: i2c_rx_timer

Overview:
- Sits directly downstream of the SCL edge detector in the I2C slave.
- Consumes the single-cycle rising/falling SCL edge strobes plus start/stop flags and a synchronized SDA sample.
- Frames each byte: shifts in data bits MSB-first, then sequences the ACK slot.
- Emits single-cycle phase strobes (byte_received, ack_prep, check_ack, ack_done) and the assembled byte to the slave controller.

Parameters:
- DATA_BITS, 8, number of data bits per I2C frame before the ACK slot (legal range 1..15).

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous, active-low reset.
- rising_edge_found  input  1  one-cycle strobe: SCL rose.
- falling_edge_found  input  1  one-cycle strobe: SCL fell.
- sda_in  input  1  synchronized SDA, delay-aligned with the edge strobes.
- start_found  input  1  one-cycle strobe: START or repeated START detected.
- stop_found  input  1  one-cycle strobe: STOP detected.
- rx_data  output  DATA_BITS  last shifted data, MSB first.
- byte_received  output  1  one-cycle strobe: DATA_BITS bits captured.
- ack_prep  output  1  one-cycle strobe: SCL fell after the last data bit; drive ACK now.
- check_ack  output  1  one-cycle strobe: SCL rose in the ACK slot; sample ACK now.
- ack_done  output  1  one-cycle strobe: SCL fell ending the ACK slot.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE, bit_cnt=0.
  - rx_data = all ones (bus-idle level).
  - All strobes 0, busy=0.
- All outputs are registered. Each strobe asserts exactly one clk after its triggering input and lasts one cycle.
- Input priority, evaluated every cycle:
  - start_found > stop_found > rising_edge_found > falling_edge_found.
  - Simultaneous rising and falling: only the rising edge is acted on.
- start_found, any state: next state BITS, bit_cnt=0, no strobe. rx_data is held (not cleared).
- stop_found, any state except via start: next state IDLE, bit_cnt=0. A partial byte is discarded: no byte_received, rx_data holds its partial shift.
- IDLE: SCL edges are ignored.
- BITS, on rising_edge_found:
  - rx_data <= {rx_data[DATA_BITS-2:0], sda_in}; bit_cnt++.
  - When bit_cnt reaches DATA_BITS: byte_received=1 on the next cycle, state -> WAIT_ACK, bit_cnt=0.
  - rx_data is valid in the same cycle that byte_received is high.
- BITS, on falling_edge_found: no action.
- WAIT_ACK: falling_edge_found -> ack_prep pulse, state -> ACK. A rising edge here is ignored.
- ACK: rising_edge_found -> check_ack pulse, state -> ACK_HOLD.
- ACK_HOLD: falling_edge_found -> ack_done pulse, state -> BITS, bit_cnt=0. The next byte follows immediately.
- bit_cnt width is 4 bits; it never wraps because it is cleared on reaching DATA_BITS.
- Reset mid-frame: immediate return to reset values; any strobe is cancelled in the same cycle.
- Latency: from rising_edge_found of the last data bit to byte_received is 1 clk.

Decomposition:
- Shared package i2c_pkg holds:
  - typedef enum logic [2:0] rx_timer_state_t {IDLE, BITS, WAIT_ACK, ACK, ACK_HOLD}.
  - localparam I2C_DATA_BITS=8.
  - localparam RX_IDLE_DATA='1.
- One natural sub-module, i2c_bit_counter: synchronous clear, enable, rollover flag at a parameterized count. It provides bit_cnt and the terminal-count flag.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset then idle: assert n_rst=0 mid-stream -> rx_data=8'hFF, all strobes 0, busy=0. SCL edges with no start -> no strobes.
- Single byte 0xA5 followed by ACK:
  - start, then 8 rising edges with sda MSB-first 1,0,1,0,0,1,0,1 -> byte_received 1 clk after the 8th rise, rx_data=8'hA5.
  - Next fall -> ack_prep; next rise -> check_ack; next fall -> ack_done. Each strobe is exactly 1 cycle.
- Back-to-back bytes 0x3C, 0xFF: no start between them -> second byte_received with rx_data=8'hFF. bit_cnt restarts after ack_done.
- Stop after 5 bits:
  - No byte_received, state IDLE, busy=0 next cycle.
  - Subsequent edges ignored until start; a new start and 8 bits of 0x01 -> rx_data=8'h01.
- Repeated start in WAIT_ACK: start_found -> state BITS, no ack_prep. A following 8-bit frame of 0x80 gives byte_received with 8'h80.
- Simultaneous start_found and stop_found in BITS -> start wins; busy stays 1 and bit_cnt=0.
